// File: rtl/drum_pkg.sv
// Shared state encoding, default sizing constants and index helpers for the drum sequencer.
package drum_pkg;

    localparam int unsigned NUM_VOICES       = 4;
    localparam int unsigned NUM_STEPS        = 16;
    localparam int unsigned SAMPLES_PER_STEP = 6000;

    // Minimum one bit so degenerate sizes still yield legal vectors.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned STEP_W = idx_width(NUM_STEPS);

    typedef logic [STEP_W-1:0] step_idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StDone
    } state_e;

endpackage

// File: rtl/step_pattern_ram.sv
// Pattern store: one trigger word per step, single write port, asynchronous read.
module step_pattern_ram
    import drum_pkg::*;
#(
    parameter int unsigned WIDTH  = NUM_VOICES,
    parameter int unsigned DEPTH  = NUM_STEPS,
    parameter int unsigned ADDR_W = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/drum_sequencer.sv
// Per-sample frame sequencer: starts all voices on a sample tick, waits for every voice
// to finish, then advances the sample/step counters through the stored pattern.
module drum_sequencer #(
    parameter int unsigned  NUM_VOICES       = drum_pkg::NUM_VOICES,
    parameter int unsigned  NUM_STEPS        = drum_pkg::NUM_STEPS,
    parameter int unsigned  SAMPLES_PER_STEP = drum_pkg::SAMPLES_PER_STEP,
    localparam int unsigned STEP_W           = drum_pkg::idx_width(NUM_STEPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic                  run,
    input  logic                  pat_we,
    input  logic [STEP_W-1:0]     pat_addr,
    input  logic [NUM_VOICES-1:0] pat_data,
    output logic                  voice_start,
    output logic [NUM_VOICES-1:0] voice_trigger,
    input  logic [NUM_VOICES-1:0] voice_finish,
    output logic                  frame_done,
    output logic [STEP_W-1:0]     step,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    import drum_pkg::*;

    localparam int unsigned       CNT_W     = idx_width(SAMPLES_PER_STEP);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLES_PER_STEP - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

    state_e                state_q, state_d;
    logic [NUM_VOICES-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic                  overrun_q, overrun_d;
    logic [NUM_VOICES-1:0] pat_rdata;

    step_pattern_ram #(
        .WIDTH  (NUM_VOICES),
        .DEPTH  (NUM_STEPS),
        .ADDR_W (STEP_W)
    ) u_pattern (
        .clk   (clk),
        .rst   (rst),
        .we    (pat_we),
        .waddr (pat_addr),
        .wdata (pat_data),
        .raddr (step_q),
        .rdata (pat_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mask_q       <= '0;
            sample_cnt_q <= '0;
            step_q       <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            sample_cnt_q <= sample_cnt_d;
            step_q       <= step_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        voice_start   = 1'b0;
        voice_trigger = '0;
        frame_done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sample_tick) begin
                    state_d = StStart;
                    mask_d  = '0;
                end
            end
            StStart: begin
                voice_start = 1'b1;
                mask_d      = mask_q | voice_finish;
                // Triggers fire only on the first sample of a step.
                if (run && (sample_cnt_q == '0)) begin
                    voice_trigger = pat_rdata;
                end
                state_d = StWait;
            end
            StWait: begin
                mask_d = mask_q | voice_finish;
                if (&(mask_q | voice_finish)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                frame_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        step_d       = step_q;
        if (state_q == StDone) begin
            if (!run) begin
                sample_cnt_d = '0;
                step_d       = '0;
            end else if (sample_cnt_q == CNT_LAST) begin
                sample_cnt_d = '0;
                step_d       = (step_q == STEP_LAST) ? '0 : step_q + STEP_W'(1);
            end else begin
                sample_cnt_d = sample_cnt_q + CNT_W'(1);
            end
        end
    end

    // A tick can only be accepted in idle; set has priority over clear.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (sample_tick && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    assign step    = step_q;
    assign overrun = overrun_q;

endmodule
